// File: rtl/fir_trigger_pkg.sv
// Shared types and elaboration-time helpers for the trigger front end
// (baseline tracking and CFD extraction).
package fir_trigger_pkg;

    typedef enum logic {
        BT_ACCEPT = 1'b0,
        BT_HOLD   = 1'b1
    } bt_state_e;

    // Bits needed to hold values 0..value; never less than 1.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while (((1 << w) <= value) && (w < 31)) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Window length in 4-sample groups for a given sum/sample width pair.
    function automatic int bsum_ngroups(input int bsumbits, input int inbits);
        return (1 << (bsumbits - inbits)) / 4;
    endfunction

    // Offset binary to two's complement: flip the sample MSB.
    function automatic logic [31:0] unsigned_to_signed(input logic [31:0] raw, input int bits);
        return raw ^ (32'd1 << (bits - 1));
    endfunction

endpackage

// File: rtl/bsum_window.sv
// Sliding window of committed group sums with a running total and fill count.
module bsum_window
    import fir_trigger_pkg::*;
#(
    parameter int GW = 16,
    parameter int SW = 18,
    parameter int NG = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          commit,
    input  logic [GW-1:0] data,
    output logic [SW-1:0] sum,
    output logic          valid
);

    localparam int FW = clog2_min1(NG);

    logic signed [GW-1:0] win [NG];
    logic signed [GW-1:0] data_s;
    logic signed [SW-1:0] sum_q;
    logic signed [SW-1:0] add_ext;
    logic signed [SW-1:0] sub_ext;
    logic [FW-1:0]        fill;
    logic [FW-1:0]        fill_next;
    logic                 valid_q;

    assign data_s    = $signed(data);
    assign add_ext   = SW'(data_s);
    assign sub_ext   = SW'(win[NG-1]);
    assign fill_next = (fill == FW'(NG)) ? fill : fill + FW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NG; i++) begin
                win[i] <= '0;
            end
            sum_q   <= '0;
            fill    <= '0;
            valid_q <= 1'b0;
        end else if (commit) begin
            win[0] <= data_s;
            for (int i = 1; i < NG; i++) begin
                win[i] <= win[i-1];
            end
            // Wraps modulo 2^SW; the true window sum always fits.
            sum_q   <= sum_q + add_ext - sub_ext;
            fill    <= fill_next;
            valid_q <= (fill_next == FW'(NG));
        end
    end

    assign sum   = sum_q;
    assign valid = valid_q;

endmodule

// File: rtl/baseline_sum_tracker.sv
// Baseline sum over the last NGROUPS clean groups, vetoing groups near a TOT pulse.
module baseline_sum_tracker
    import fir_trigger_pkg::*;
#(
    parameter int INBITS   = 14,
    parameter int BSUMBITS = 18,
    parameter int HOLDOFF  = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [INBITS-1:0]   in_0,
    input  logic [INBITS-1:0]   in_1,
    input  logic [INBITS-1:0]   in_2,
    input  logic [INBITS-1:0]   in_3,
    input  logic                tot_0,
    input  logic                tot_1,
    input  logic                tot_2,
    input  logic                tot_3,
    output logic [BSUMBITS-1:0] bsum_out,
    output logic                bsum_valid
);

    localparam int NGROUPS = bsum_ngroups(BSUMBITS, INBITS);
    localparam int GW      = INBITS + 2;
    localparam int CW      = clog2_min1(HOLDOFF);

    bt_state_e            state;
    logic [CW-1:0]        hold_cnt;
    logic signed [GW-1:0] pending;
    logic                 pend_valid;
    logic signed [GW-1:0] gsum;
    logic [INBITS-1:0]    raw [4];
    logic signed [INBITS-1:0] samp;
    logic                 tot_any;
    logic                 commit;

    assign raw[0]  = in_0;
    assign raw[1]  = in_1;
    assign raw[2]  = in_2;
    assign raw[3]  = in_3;
    assign tot_any = tot_0 | tot_1 | tot_2 | tot_3;

    always_comb begin
        gsum = '0;
        samp = '0;
        for (int i = 0; i < 4; i++) begin
            samp = $signed(INBITS'(unsigned_to_signed(32'(raw[i]), INBITS)));
            gsum = gsum + GW'(samp);
        end
    end

    // A group is committed only once a clean successor proves it was not pre-pulse.
    assign commit = !tot_any && (state == BT_ACCEPT) && pend_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= BT_ACCEPT;
            hold_cnt   <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
        end else if (tot_any) begin
            pend_valid <= 1'b0;
            hold_cnt   <= CW'(HOLDOFF);
            state      <= (HOLDOFF > 0) ? BT_HOLD : BT_ACCEPT;
        end else if (state == BT_HOLD) begin
            hold_cnt <= hold_cnt - CW'(1);
            if (hold_cnt == CW'(1)) begin
                state <= BT_ACCEPT;
            end
        end else begin
            pending    <= gsum;
            pend_valid <= 1'b1;
        end
    end

    bsum_window #(
        .GW (GW),
        .SW (BSUMBITS),
        .NG (NGROUPS)
    ) u_window (
        .clk     (clk),
        .reset_n (reset_n),
        .commit  (commit),
        .data    (pending),
        .sum     (bsum_out),
        .valid   (bsum_valid)
    );

endmodule

// File: tb/tb_baseline_sum_tracker.sv
// Directed bench for baseline_sum_tracker: a vector table plus hand sequences,
// with a second instance built for HOLDOFF=0.
module tb_baseline_sum_tracker;

    logic        clk;
    logic        reset_n;
    logic [13:0] in_0, in_1, in_2, in_3;
    logic        tot_0, tot_1, tot_2, tot_3;
    logic [17:0] bsum_out, bsum_out0;
    logic        bsum_valid, bsum_valid0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    baseline_sum_tracker #(.INBITS(14), .BSUMBITS(18), .HOLDOFF(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
        .tot_0(tot_0), .tot_1(tot_1), .tot_2(tot_2), .tot_3(tot_3),
        .bsum_out(bsum_out), .bsum_valid(bsum_valid)
    );

    baseline_sum_tracker #(.INBITS(14), .BSUMBITS(18), .HOLDOFF(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
        .tot_0(tot_0), .tot_1(tot_1), .tot_2(tot_2), .tot_3(tot_3),
        .bsum_out(bsum_out0), .bsum_valid(bsum_valid0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] s0, s1, s2, s3;
        logic [3:0]  tot;
        int          exp_sum;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input logic [3:0] t, input int es, input logic ev);
        vec_t v;
        v.s0 = 14'(a); v.s1 = 14'(b); v.s2 = 14'(c); v.s3 = 14'(d);
        v.tot = t; v.exp_sum = es; v.exp_valid = ev;
        return v;
    endfunction

    task automatic drive(input int a, input int b, input int c, input int d, input logic [3:0] t);
        in_0 = 14'(a); in_1 = 14'(b); in_2 = 14'(c); in_3 = 14'(d);
        {tot_3, tot_2, tot_1, tot_0} = t;
    endtask

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d (0x%h) want %0d (0x%h)",
                     name, cyc, $signed(act), act, $signed(exp), exp);
        end
    endtask

    // Cycle c: inputs held from posedge+1, outputs compared at the negedge.
    task automatic to_negedge();
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step(input int v, input logic [3:0] t);
        drive(v, v, v, v, t);
        to_negedge();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        drive(8192, 8192, 8192, 8192, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(8192, 8192, 8192, 8192, 4'b0000);
        @(negedge clk);
        chk("reset_sum", bsum_out, 18'd0);
        chk("reset_valid", 18'(bsum_valid), 18'd0);

        // Fill, mixed-sample group, window slide and pulse veto; t = 15.
        for (int c = 0; c < 6; c++) begin
            int e;
            e = (c < 2) ? 0 : (c - 1) * 400;
            vecs.push_back(mk(8292, 8292, 8292, 8292, 4'b0000, e, c == 5));
        end
        vecs.push_back(mk(8242, 8342, 8142, 8442, 4'b0000, 1600, 1'b1));
        vecs.push_back(mk(8242, 8342, 8142, 8442, 4'b0000, 1600, 1'b1));
        vecs.push_back(mk(8193, 8194, 8195, 8196, 4'b0000, 1600, 1'b1));
        vecs.push_back(mk(8292, 8292, 8292, 8292, 4'b0000, 1600, 1'b1));
        for (int c = 10; c < 14; c++) vecs.push_back(mk(8292, 8292, 8292, 8292, 4'b0000, 1210, 1'b1));
        vecs.push_back(mk(8292, 8292, 8292, 8292, 4'b0000, 1600, 1'b1));
        vecs.push_back(mk(9192, 9192, 9192, 9192, 4'b0100, 1600, 1'b1));
        for (int c = 16; c < 26; c++) vecs.push_back(mk(8192, 8192, 8192, 8192, 4'b0000, 1600, 1'b1));
        vecs.push_back(mk(8192, 8192, 8192, 8192, 4'b0000, 1200, 1'b1));
        vecs.push_back(mk(8192, 8192, 8192, 8192, 4'b0000, 800, 1'b1));
        vecs.push_back(mk(8192, 8192, 8192, 8192, 4'b0000, 400, 1'b1));
        vecs.push_back(mk(8192, 8192, 8192, 8192, 4'b0000, 0, 1'b1));

        apply_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].tot);
            to_negedge();
            chk("table_sum", bsum_out, 18'(vecs[i].exp_sum));
            chk("table_valid", 18'(bsum_valid), 18'(vecs[i].exp_valid));
            next_cycle();
        end

        // Hold restart: TOT at t=10 and t+5; first drop must be at t+16.
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            step(8292, 4'b0000);
            next_cycle();
        end
        for (int c = 10; c < 30; c++) begin
            step(8192, (c == 10 || c == 15) ? 4'b0001 : 4'b0000);
            if (c == 21) chk("restart_no_early_drop", bsum_out, 18'd1600);
            if (c == 25) chk("restart_last_hold", bsum_out, 18'd1600);
            if (c == 26) chk("restart_first_drop", bsum_out, 18'd1200);
            if (c == 27) chk("restart_second_drop", bsum_out, 18'd800);
            next_cycle();
        end

        // Negative baseline, then asynchronous reset mid-cycle.
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            step(8092, 4'b0000);
            if (c == 2) chk("neg_sum_c2", bsum_out, -18'sd400);
            if (c == 4) chk("neg_valid_c4", 18'(bsum_valid), 18'd0);
            if (c == 5) chk("neg_sum_c5", bsum_out, 18'h3F9C0);
            if (c == 5) chk("neg_valid_c5", 18'(bsum_valid), 18'd1);
            next_cycle();
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_sum", bsum_out, 18'd0);
        chk("async_valid", 18'(bsum_valid), 18'd0);
        chk("async_sum0", bsum_out0, 18'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        for (int c = 0; c < 10; c++) begin
            step(8292, 4'b0000);
            if (c >= 2 && c <= 5) begin
                chk("refill_sum", bsum_out, 18'((c - 1) * 400));
                chk("refill_valid", 18'(bsum_valid), 18'(c == 5));
                chk("refill_sum0", bsum_out0, 18'((c - 1) * 400));
            end
            next_cycle();
        end

        // HOLDOFF=0 instance: TOT at t=10 drops groups t-1 and t only.
        for (int c = 10; c < 16; c++) begin
            step(8192, (c == 10) ? 4'b0010 : 4'b0000);
            if (c == 11 || c == 12) chk("h0_hold_sum", bsum_out0, 18'd1600);
            if (c == 13) chk("h0_first_drop", bsum_out0, 18'd1200);
            if (c == 14) chk("h0_second_drop", bsum_out0, 18'd800);
            if (c == 13) chk("h8_still_holding", bsum_out, 18'd1600);
            if (c == 14) chk("h0_valid", 18'(bsum_valid0), 18'd1);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
